// File: rtl/tropang_rom_router.sv
// tropang_rom_router
//   Bridges the hps_io ioctl download stream to the TropicalAngel core.
//   - Index 0: linear ROM image, decoded into one-hot per-region write strobes with
//     region-local addresses; byte count and range errors tracked per download.
//   - Index DIP_INDEX: bytes 0/1 captured into dip_sw.
//   - core_reset holds the core in reset until a complete, in-range image has loaded.
// Ports
//   clk_sys          system clock
//   reset            synchronous active-high power-on/OSD reset
//   ioctl_download   download active
//   ioctl_wr         one-cycle byte-valid strobe
//   ioctl_addr       byte address within the download
//   ioctl_dout       byte data
//   ioctl_index      download index
//   dl_addr/dl_data  registered region-local address / data
//   dl_we            one-hot strobe: cpu,snd,gfx1,gfx2,chr_pal_lo,chr_pal_hi,spr_pal,spr_lut
//   dip_sw           {sw[1], sw[0]}
//   rom_loaded       last index-0 download complete and in range
//   rom_err          last index-0 download short, long or out of range
//   core_reset       core reset request
module tropang_rom_router #(
    parameter logic [16:0] ROM_SIZE  = 17'h1C320,
    parameter logic [7:0]  DIP_INDEX = 8'd254
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic [15:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic [7:0]  dl_we,
    output logic [15:0] dip_sw,
    output logic        rom_loaded,
    output logic        rom_err,
    output logic        core_reset
);

    typedef enum logic [1:0] {StIdle, StLoad, StDoneOk, StDoneErr} state_e;

    state_e      state_q, state_d;
    logic [17:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        dl_prev_q;
    logic [7:0]  we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] dip_q, dip_d;
    logic        loaded_q, loaded_d;
    logic        rom_err_q, rom_err_d;

    logic        in_range;
    logic [16:0] a17;
    logic [7:0]  dec_we;
    logic [16:0] dec_base;
    logic [16:0] dec_diff;
    logic        accept;
    logic        dl_rise;
    logic [17:0] cnt_inc;
    logic        image_ok;

    assign a17      = ioctl_addr[16:0];
    // Covers any of bits 24:17 being set as well.
    assign in_range = ioctl_addr < {8'd0, ROM_SIZE};
    assign dec_diff = a17 - dec_base;
    assign dl_rise  = ioctl_download & ~dl_prev_q;
    // In LOAD a byte is taken even on the falling-download cycle so it is counted first.
    assign accept   = (state_q == StLoad) & ioctl_wr;
    assign cnt_inc  = (cnt_q == 18'h3FFFF) ? cnt_q : cnt_q + 18'd1;

    // Region decode
    always_comb begin
        dec_we   = 8'h00;
        dec_base = 17'h00000;
        if (in_range) begin
            if (a17 < 17'h08000) begin
                dec_we = 8'h01; dec_base = 17'h00000;
            end else if (a17 < 17'h0A000) begin
                dec_we = 8'h02; dec_base = 17'h08000;
            end else if (a17 < 17'h10000) begin
                dec_we = 8'h04; dec_base = 17'h0A000;
            end else if (a17 < 17'h1C000) begin
                dec_we = 8'h08; dec_base = 17'h10000;
            end else if (a17 < 17'h1C100) begin
                dec_we = 8'h10; dec_base = 17'h1C000;
            end else if (a17 < 17'h1C200) begin
                dec_we = 8'h20; dec_base = 17'h1C100;
            end else if (a17 < 17'h1C300) begin
                dec_we = 8'h40; dec_base = 17'h1C200;
            end else if (a17 < 17'h1C320) begin
                dec_we = 8'h80; dec_base = 17'h1C300;
            end
        end
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        loaded_d  = loaded_q;
        rom_err_d = rom_err_q;
        we_d      = 8'h00;
        addr_d    = addr_q;
        data_d    = data_q;
        dip_d     = dip_q;
        image_ok  = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    cnt_d  = cnt_inc;
                    err_d  = err_q | ~in_range;
                    we_d   = dec_we;
                    if (dec_we != 8'h00) begin
                        addr_d = dec_diff[15:0];
                        data_d = ioctl_dout;
                    end
                end
                if (!ioctl_download) begin
                    image_ok  = (cnt_d == {1'b0, ROM_SIZE}) && !err_d;
                    state_d   = image_ok ? StDoneOk : StDoneErr;
                    loaded_d  = image_ok;
                    rom_err_d = ~image_ok;
                end
            end
            StIdle, StDoneOk, StDoneErr: begin
                // Only a fresh rising edge starts a load, so a download aborted by reset
                // stays ignored until the next one.
                if (dl_rise && ioctl_index == 8'd0) begin
                    state_d   = StLoad;
                    cnt_d     = 18'd0;
                    err_d     = 1'b0;
                    loaded_d  = 1'b0;
                    rom_err_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (ioctl_download && ioctl_wr && ioctl_index == DIP_INDEX) begin
            if (ioctl_addr == 25'd0) begin
                dip_d[7:0] = ioctl_dout;
            end else if (ioctl_addr == 25'd1) begin
                dip_d[15:8] = ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        // Tracked through reset so a download in progress is not mistaken for a new start.
        dl_prev_q <= ioctl_download;
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 18'd0;
            err_q     <= 1'b0;
            we_q      <= 8'h00;
            addr_q    <= 16'h0000;
            data_q    <= 8'h00;
            dip_q     <= 16'h0000;
            loaded_q  <= 1'b0;
            rom_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            dip_q     <= dip_d;
            loaded_q  <= loaded_d;
            rom_err_q <= rom_err_d;
        end
    end

    assign dl_we      = we_q;
    assign dl_addr    = addr_q;
    assign dl_data    = data_q;
    assign dip_sw     = dip_q;
    assign rom_loaded = loaded_q;
    assign rom_err    = rom_err_q;
    assign core_reset = reset | (state_q != StDoneOk);

endmodule

// File: tb/tb_tropang_rom_router.sv
// Bench for tropang_rom_router: two instances (full-size image and a 32-byte image so a
// complete load fits in a short run) driven by the same stream, checked every cycle
// against a region-table model, plus literal expectations at key points.
module tb_tropang_rom_router;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;

    logic [15:0] a_addr, b_addr, a_dip, b_dip;
    logic [7:0]  a_data, b_data, a_we, b_we;
    logic        a_ld, b_ld, a_er, b_er, a_cr, b_cr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tropang_rom_router u_a (
        .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .dl_addr(a_addr), .dl_data(a_data), .dl_we(a_we), .dip_sw(a_dip),
        .rom_loaded(a_ld), .rom_err(a_er), .core_reset(a_cr)
    );

    tropang_rom_router #(.ROM_SIZE(17'h00020), .DIP_INDEX(8'd254)) u_b (
        .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .dl_addr(b_addr), .dl_data(b_data), .dl_we(b_we), .dip_sw(b_dip),
        .rom_loaded(b_ld), .rom_err(b_er), .core_reset(b_cr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Region table: base address, strobe bit; a region ends where the next begins.
    int rbase[9] = '{'h00000, 'h08000, 'h0A000, 'h10000, 'h1C000,
                     'h1C100, 'h1C200, 'h1C300, 'h1C320};
    int        msize[2] = '{'h1C320, 'h20};
    bit        mloading[2];
    bit        mok[2];
    bit        mbad[2];
    int        mcnt[2];
    logic [7:0]  mwe[2];
    logic [15:0] maddr[2];
    logic [7:0]  mdata[2];
    logic [15:0] mdip[2];
    bit        mld[2];
    bit        mer[2];
    bit        mprev = 1'b0;
    bit        mvalid = 1'b0;

    always @(posedge clk) begin
        int a;
        a = int'(ioctl_addr);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mloading[k] = 0; mok[k] = 0; mbad[k] = 0; mcnt[k] = 0;
                mwe[k] = 0; maddr[k] = 0; mdata[k] = 0; mdip[k] = 0;
                mld[k] = 0; mer[k] = 0;
            end else begin
                mwe[k] = 8'h00;
                if (ioctl_download && ioctl_wr && ioctl_index == 8'd254) begin
                    if (a == 0) mdip[k][7:0] = ioctl_dout;
                    if (a == 1) mdip[k][15:8] = ioctl_dout;
                end
                if (mloading[k]) begin
                    if (ioctl_wr) begin
                        mcnt[k] = (mcnt[k] >= 'h3FFFF) ? 'h3FFFF : mcnt[k] + 1;
                        if (a >= msize[k]) mbad[k] = 1;
                        else begin
                            for (int r = 0; r < 8; r++)
                                if (a >= rbase[r] && a < rbase[r+1]) begin
                                    mwe[k]   = 8'(1 << r);
                                    maddr[k] = 16'(a - rbase[r]);
                                    mdata[k] = ioctl_dout;
                                end
                        end
                    end
                    if (!ioctl_download) begin
                        mloading[k] = 0;
                        mok[k] = (mcnt[k] == msize[k]) && !mbad[k];
                        mld[k] = mok[k];
                        mer[k] = !mok[k];
                    end
                end else if (ioctl_download && !mprev && ioctl_index == 8'd0) begin
                    mloading[k] = 1; mok[k] = 0; mbad[k] = 0; mcnt[k] = 0;
                    mld[k] = 0; mer[k] = 0;
                end
            end
        end
        mprev  = ioctl_download;
        mvalid = 1'b1;
    end

    task automatic cmp(input int k, input logic [7:0] we, input logic [15:0] ad,
                       input logic [7:0] da, input logic [15:0] dp, input logic ld,
                       input logic er, input logic cr);
        string p;
        p = (k == 0) ? "a" : "b";
        chk({p, " dl_we"}, {24'd0, we}, {24'd0, mwe[k]});
        chk({p, " dl_addr"}, {16'd0, ad}, {16'd0, maddr[k]});
        chk({p, " dl_data"}, {24'd0, da}, {24'd0, mdata[k]});
        chk({p, " dip_sw"}, {16'd0, dp}, {16'd0, mdip[k]});
        chk({p, " rom_loaded"}, {31'd0, ld}, {31'd0, mld[k]});
        chk({p, " rom_err"}, {31'd0, er}, {31'd0, mer[k]});
        chk({p, " core_reset"}, {31'd0, cr}, {31'd0, reset | !mok[k] | mloading[k]});
    endtask

    always @(posedge clk) begin
        #1;
        if (mvalid) begin
            cmp(0, a_we, a_addr, a_data, a_dip, a_ld, a_er, a_cr);
            cmp(1, b_we, b_addr, b_data, b_dip, b_ld, b_er, b_cr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int a, input logic [7:0] d);
        @(negedge clk);
        ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = d;
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic dl_start(input logic [7:0] idx);
        @(negedge clk);
        ioctl_download = 1'b1; ioctl_index = idx;
        @(negedge clk);
    endtask

    task automatic dl_end();
        @(negedge clk);
        ioctl_download = 1'b0;
        @(negedge clk);
    endtask

    int tab_a[10]  = '{'h0A000, 'h08005, 'h10123, 'h1C0AB, 'h1C1CD,
                       'h1C2EF, 'h00ABC, 'h1C31F, 'h1C320, 'h1FFFFFF};
    int tab_we[10] = '{'h04, 'h02, 'h08, 'h10, 'h20, 'h40, 'h01, 'h80, 'h00, 'h00};
    int tab_ad[10] = '{'h0000, 'h0005, 'h0123, 'h00AB, 'h00CD,
                       'h00EF, 'h0ABC, 'h001F, 'h001F, 'h001F};

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        repeat (3) @(negedge clk);
        chk("reset dl_we", {24'd0, a_we}, 32'h0);
        chk("reset core_reset", {31'd0, a_cr}, 32'h1);
        chk("reset dip_sw", {16'd0, a_dip}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle core_reset", {31'd0, b_cr}, 32'h1);

        // DIP bytes
        dl_start(8'd254);
        send(0, 8'hA5); send(1, 8'h3C); send(2, 8'hFF);
        dl_end();
        chk("dip 3CA5", {16'd0, a_dip}, 32'h3CA5);
        chk("dip state idle", {31'd0, a_cr}, 32'h1);
        chk("dip no load", {31'd0, b_ld}, 32'h0);
        send(0, 8'h00);  // wr without download: ignored
        chk("dip ignored", {16'd0, b_dip}, 32'h3CA5);

        // Region decode on full-size instance; out-of-range bytes make it an error load
        dl_start(8'd0);
        for (int i = 0; i < 10; i++) begin
            send(tab_a[i], 8'(8'h11 + i));
            chk($sformatf("decode we %0h", tab_a[i]), {24'd0, a_we}, 32'(tab_we[i]));
            chk($sformatf("decode addr %0h", tab_a[i]), {16'd0, a_addr}, 32'(tab_ad[i]));
            if (tab_we[i] != 0)
                chk($sformatf("decode data %0h", tab_a[i]), {24'd0, a_data}, 32'(8'h11 + i));
        end
        dl_end();
        chk("range err", {31'd0, a_er}, 32'h1);
        chk("range not loaded", {31'd0, a_ld}, 32'h0);

        // Complete small image; last byte arrives with falling download
        dl_start(8'd0);
        for (int i = 0; i < 31; i++) send(i, 8'(i * 3));
        @(negedge clk);
        ioctl_download = 1'b0; ioctl_wr = 1'b1; ioctl_addr = 25'h1F; ioctl_dout = 8'h77;
        @(negedge clk);
        ioctl_wr = 1'b0;
        chk("b loaded", {31'd0, b_ld}, 32'h1);
        chk("b core run", {31'd0, b_cr}, 32'h0);
        chk("b no err", {31'd0, b_er}, 32'h0);
        chk("a short err", {31'd0, a_er}, 32'h1);
        chk("a short reset", {31'd0, a_cr}, 32'h1);

        // DIP update while loaded
        dl_start(8'd254);
        send(1, 8'h5A);
        dl_end();
        chk("dip in done", {16'd0, b_dip}, 32'h5AA5);
        chk("dip keep loaded", {31'd0, b_ld}, 32'h1);

        // Reload
        dl_start(8'd0);
        chk("reload core_reset", {31'd0, b_cr}, 32'h1);
        chk("reload not loaded", {31'd0, b_ld}, 32'h0);
        for (int i = 0; i < 32; i++) send(i, 8'(i));
        dl_end();
        chk("reload loaded", {31'd0, b_ld}, 32'h1);

        // Reset mid-download
        dl_start(8'd0);
        for (int i = 0; i < 16; i++) send(i, 8'(i));
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int i = 16; i < 32; i++) begin
            send(i, 8'(i));
            chk("abort no strobe", {24'd0, b_we}, 32'h0);
        end
        dl_end();
        chk("abort not loaded", {31'd0, b_ld}, 32'h0);
        chk("abort core_reset", {31'd0, b_cr}, 32'h1);
        chk("abort dip cleared", {16'd0, b_dip}, 32'h0);

        // Count matches but one byte out of range
        dl_start(8'd0);
        for (int i = 0; i < 31; i++) send(i, 8'(i));
        send('h20, 8'hEE);
        chk("oor no strobe", {24'd0, b_we}, 32'h0);
        dl_end();
        chk("oor err", {31'd0, b_er}, 32'h1);
        chk("oor not loaded", {31'd0, b_ld}, 32'h0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
